// File: rtl/alu_pkg.sv
// Shared ALU unit-block types and default operand/result widths.
package alu_pkg;

  localparam int MUL_IN_WL  = 15;
  localparam int MUL_OUT_WL = 16;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per clock.
// Latency: out_valid rises IN_WL edges after the accepting edge; no overlap between operations.
// Backpressure: the result is held in DONE until out_ready; in_ready stays low outside IDLE.
module mul_seq
  import alu_pkg::*;
#(
  parameter int IN_WL  = MUL_IN_WL,
  parameter int OUT_WL = MUL_OUT_WL
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_WL-1:0]  a,
  input  logic [IN_WL-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_WL-1:0] r,
  output logic              ovf
);

  localparam int ACC_WL = 2 * IN_WL;
  localparam int CNT_WL = $clog2(IN_WL);

  mul_state_t          state, state_nxt;
  logic [IN_WL-1:0]    a_reg, b_reg;
  logic [ACC_WL-1:0]   acc, acc_nxt;
  logic [CNT_WL-1:0]   cnt;
  logic                ovf_nxt;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    unique case (state)
      MUL_IDLE: if (in_valid && in_ready) state_nxt = MUL_BUSY;
      MUL_BUSY: begin
        if (b_reg[0]) acc_nxt = acc + (ACC_WL'(a_reg) << cnt);
        if (cnt == CNT_WL'(IN_WL - 1)) state_nxt = MUL_DONE;
      end
      MUL_DONE: if (out_valid && out_ready) state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // A full-width result has no bits left to overflow into.
  generate
    if (OUT_WL < ACC_WL) begin : g_ovf
      assign ovf_nxt = |acc_nxt[ACC_WL-1:OUT_WL];
    end else begin : g_no_ovf
      assign ovf_nxt = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= MUL_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      r         <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == MUL_IDLE);
      out_valid <= (state_nxt == MUL_DONE);
      unique case (state)
        MUL_IDLE: if (in_valid && in_ready) begin
          a_reg <= a;
          b_reg <= b;
          acc   <= '0;
          cnt   <= '0;
        end
        MUL_BUSY: begin
          acc   <= acc_nxt;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          // Capture on DONE entry so r/ovf include the final partial product.
          if (state_nxt == MUL_DONE) begin
            r   <= acc_nxt[OUT_WL-1:0];
            ovf <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rstb;
  logic        in_valid;
  logic [14:0] a, b;
  logic        out_ready;
  logic        in_ready, out_valid, ovf;
  logic [15:0] r;
  logic        in_ready30, out_valid30, ovf30;
  logic [29:0] r30;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  always #5 clk = ~clk;

  mul_seq #(.IN_WL(15), .OUT_WL(16)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .ovf(ovf)
  );

  mul_seq #(.IN_WL(15), .OUT_WL(30)) dut30 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready30),
    .a(a), .b(b), .out_valid(out_valid30), .out_ready(out_ready),
    .r(r30), .ovf(ovf30)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [14:0] av, input logic [14:0] bv);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (l < 40) begin
      @(posedge clk); #1;
      l++;
      if (out_valid) break;
    end
    if (!out_valid) check_eq("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    logic seen_bad;
    rstb = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    check_eq("rst_in_ready",  64'(in_ready),   64'd0);
    check_eq("rst_in_ready30", 64'(in_ready30), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid),  64'd0);
    check_eq("rst_r",         64'(r),          64'd0);
    check_eq("rst_ovf",       64'(ovf),        64'd0);
    @(negedge clk) rstb = 1'b1;

    // 3*5, consumer always ready
    start_op(15'd3, 15'd5);
    wait_done(lat);
    check_eq("t1_latency", 64'(lat), 64'd15);
    check_eq("t1_r",       64'(r),   64'd15);
    check_eq("t1_ovf",     64'(ovf), 64'd0);
    @(posedge clk); #1;
    check_eq("t1_ov_drop", 64'(out_valid), 64'd0);
    check_eq("t1_rdy_up",  64'(in_ready),  64'd1);

    start_op(15'd255, 15'd257);
    wait_done(lat);
    check_eq("t2_r",   64'(r),   64'hFFFF);
    check_eq("t2_ovf", 64'(ovf), 64'd0);

    start_op(15'd256, 15'd256);
    wait_done(lat);
    check_eq("t3_r",   64'(r),   64'd0);
    check_eq("t3_ovf", 64'(ovf), 64'd1);

    // full-width product on the 30-bit instance, truncated on the 16-bit one
    start_op(15'h7FFF, 15'h7FFF);
    wait_done(lat);
    check_eq("t4_r30",   64'(r30),   64'h3FFF0001);
    check_eq("t4_ovf30", 64'(ovf30), 64'd0);
    check_eq("t4_ov30",  64'(out_valid30), 64'd1);
    check_eq("t4_r16",   64'(r),     64'h0001);
    check_eq("t4_ovf16", 64'(ovf),   64'd1);

    // zero operand, stray in_valid during BUSY must be ignored
    start_op(15'd0, 15'h1234);
    repeat (3) begin @(posedge clk); #1; end
    a = 15'd5; b = 15'd5; in_valid = 1'b1;
    seen_bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (in_ready) seen_bad = 1'b1;
    end
    in_valid = 1'b0;
    wait_done(lat);
    check_eq("t5_rdy_busy", 64'(seen_bad), 64'd0);
    check_eq("t5_latency",  64'(lat + 6), 64'd15);
    check_eq("t5_r",        64'(r),   64'd0);
    check_eq("t5_ovf",      64'(ovf), 64'd0);
    seen_bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen_bad = 1'b1;
    end
    check_eq("t5_no_spurious", 64'(seen_bad), 64'd0);

    // result held under backpressure
    out_ready = 1'b0;
    start_op(15'd11, 15'd13);
    wait_done(lat);
    check_eq("t6_latency", 64'(lat), 64'd15);
    seen_bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || r !== 16'd143 || in_ready) seen_bad = 1'b1;
    end
    check_eq("t6_hold", 64'(seen_bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_ov_drop", 64'(out_valid), 64'd0);
    check_eq("t6_rdy_up",  64'(in_ready),  64'd1);
    check_eq("t6_r_keep",  64'(r),         64'd143);

    // reset mid-BUSY abandons the operation
    start_op(15'd100, 15'd3);
    repeat (7) begin @(posedge clk); #1; end
    rstb = 1'b0;
    #1;
    check_eq("t7_rst_r",   64'(r),         64'd0);
    check_eq("t7_rst_ov",  64'(out_valid), 64'd0);
    check_eq("t7_rst_rdy", 64'(in_ready),  64'd0);
    @(negedge clk) rstb = 1'b1;
    seen_bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen_bad = 1'b1;
    end
    check_eq("t7_abandoned", 64'(seen_bad), 64'd0);
    start_op(15'd2, 15'd9);
    wait_done(lat);
    check_eq("t7_latency", 64'(lat), 64'd15);
    check_eq("t7_r",       64'(r),   64'd18);

    // operands changed right after acceptance have no effect
    start_op(15'd6, 15'd7);
    a = 15'd99; b = 15'd99;
    wait_done(lat);
    check_eq("t8_r", 64'(r), 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
